// File: rtl/dmem_pkg.sv
// Shared encodings and widths for the data-memory responder.
package dmem_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 4;

   localparam logic SZ_BYTE = 1'b0;
   localparam logic SZ_WORD = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dmem_state_t;

   function automatic logic [DATA_W-1:0] extend_byte(input logic [7:0] b, input logic sgn);
      return sgn ? {{(DATA_W-8){b[7]}}, b} : {{(DATA_W-8){1'b0}}, b};
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel bundle between the data-memory port and its responder.
interface dmem_responder_if
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic              req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_array.sv
// Byte-wide storage with combinational big-endian word read and synchronous byte/word write.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DEPTH  = 256
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic              word_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [7:0] bytes [DEPTH];

   logic [ADDR_W-1:0] addr1, addr2, addr3;

   always_comb begin
      addr1 = addr_i + ADDR_W'(1);
      addr2 = addr_i + ADDR_W'(2);
      addr3 = addr_i + ADDR_W'(3);
   end

   // Lowest address holds the most significant byte.
   assign rdata_o = {bytes[addr_i], bytes[addr1], bytes[addr2], bytes[addr3]};

   always_ff @(posedge clk) begin
      if (we_i) begin
         if (word_i) begin
            bytes[addr_i] <= wdata_i[31:24];
            bytes[addr1]  <= wdata_i[23:16];
            bytes[addr2]  <= wdata_i[15:8];
            bytes[addr3]  <= wdata_i[7:0];
         end else begin
            bytes[addr_i] <= wdata_i[7:0];
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder over a 2**ADDR_W byte big-endian store.
// Optional misaligned-word trap: define DMEM_MISALIGN_TRAP_EN.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   dmem_responder_if.slave   bus
);

   dmem_state_t       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic              sz_q, sz_d;
   logic              sg_q, sg_d;
   logic              mis_q, mis_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              arr_we;
   logic [DATA_W-1:0] arr_rdata;

   dmem_array #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk     (clk),
      .we_i    (arr_we),
      .word_i  (sz_q),
      .addr_i  (addr_q),
      .wdata_i (wdata_q),
      .rdata_o (arr_rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      sz_d    = sz_q;
      sg_d    = sg_q;
      mis_d   = mis_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      arr_we  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               wr_d    = bus.req_write;
               sz_d    = bus.req_size;
               sg_d    = bus.req_signed;
               wdata_d = bus.req_wdata;
`ifdef DMEM_MISALIGN_TRAP_EN
               mis_d   = (bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00);
               addr_d  = bus.req_addr;
`else
               mis_d   = 1'b0;
               addr_d  = (bus.req_size == SZ_WORD) ? {bus.req_addr[ADDR_W-1:2], 2'b00}
                                                   : bus.req_addr;
`endif
               // Every access passes through WAIT so rsp_valid rises exactly LATENCY edges after accept.
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               arr_we = wr_q & ~mis_q;
               if (wr_q || mis_q) begin
                  rdata_d = '0;
               end else if (sz_q == SZ_WORD) begin
                  rdata_d = arr_rdata;
               end else begin
                  rdata_d = extend_byte(arr_rdata[31:24], sg_q);
               end
               err_d   = mis_q;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         sz_q    <= SZ_BYTE;
         sg_q    <= 1'b0;
         mis_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         sz_q    <= sz_d;
         sg_q    <= sg_d;
         mis_q   <= mis_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver queues expected responses, monitor checks them.
module tb_dmem_responder;

   localparam int unsigned LAT = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int unsigned acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dmem_responder_if #(.ADDR_W(8)) bus ();

   dmem_responder #(
      .ADDR_W  (8),
      .DEPTH   (256),
      .LATENCY (LAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc = 0;
   exp_t        sb[$];
   bit          seen = 1'b0;
   bit          bp_rand = 1'b0;
   logic        rr_force = 1'b1;
   logic [7:0]  mem [256];

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1 bus.rsp_ready = bp_rand ? 1'($urandom_range(0, 1)) : rr_force;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: plain big-endian byte array semantics.
   function automatic exp_t model(input logic wr, input logic sz, input logic sg,
                                  input logic [7:0] a, input logic [31:0] wd);
      exp_t       e;
      logic [7:0] ea;
      logic       mis;
      mis = TRAP && sz && (a % 4 != 0);
      ea  = (sz && !TRAP) ? (a & 8'hFC) : a;
      e.acc = 0;
      e.err = mis;
      e.rdata = 32'h0;
      if (!mis) begin
         if (wr) begin
            if (sz) begin
               mem[ea]        = wd[31:24];
               mem[ea + 8'd1] = wd[23:16];
               mem[ea + 8'd2] = wd[15:8];
               mem[ea + 8'd3] = wd[7:0];
            end else begin
               mem[ea] = wd[7:0];
            end
         end else if (sz) begin
            e.rdata = {mem[ea], mem[ea + 8'd1], mem[ea + 8'd2], mem[ea + 8'd3]};
         end else begin
            e.rdata = (sg && mem[ea][7]) ? (32'hFFFFFF00 | mem[ea]) : {24'h0, mem[ea]};
         end
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n && bus.rsp_valid) begin
         if (!seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
               chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               chk("rsp_rdata", bus.rsp_rdata, sb[0].rdata);
               chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, sb[0].err});
               chk("latency", cyc - sb[0].acc, LAT);
            end
         end
         if (bus.rsp_ready) begin
            if (sb.size() != 0) void'(sb.pop_front());
            seen = 1'b0;
         end
      end
   end

   task automatic issue(input logic wr, input logic sz, input logic sg, input logic [7:0] a,
                        input logic [31:0] wd, input bit track, output bit ok);
      int unsigned budget = 0;
      exp_t e;
      ok = 1'b0;
      @(posedge clk);
      #1;
      bus.req_valid  = 1'b1;
      bus.req_write  = wr;
      bus.req_size   = sz;
      bus.req_signed = sg;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      forever begin
         @(negedge clk);
         if (bus.req_ready) break;
         budget++;
         if (budget > 200) begin
            chk("req_ready_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
         end
      end
      if (track) begin
         e = model(wr, sz, sg, a, wd);
         e.acc = cyc + 1;
         sb.push_back(e);
      end
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      ok = 1'b1;
   endtask

   task automatic drain();
      int unsigned budget = 0;
      while (sb.size() != 0) begin
         @(negedge clk);
         budget++;
         if (budget > 300) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            sb.delete();
            seen = 1'b0;
         end
      end
   endtask

   task automatic xfer(input logic wr, input logic sz, input logic sg, input logic [7:0] a,
                       input logic [31:0] wd);
      bit ok;
      issue(wr, sz, sg, a, wd, 1'b1, ok);
      if (ok) drain();
   endtask

   initial begin
      bit          ok;
      logic [7:0]  old40;
      logic [31:0] hold_exp;
      int unsigned budget;

      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 1'b0;
      bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      #1;
      chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
      #20 rst_n = 1'b1;

      for (int i = 0; i < 64; i++) begin
         xfer(1'b1, 1'b1, 1'b0, 8'(i * 4), (i == 4) ? 32'hDEADBEEF : $urandom);
      end

      xfer(1'b0, 1'b1, 1'b0, 8'h10, 32'h0);
      chk("preload_word", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, 32'hDEADBEEF);
      xfer(1'b0, 1'b0, 1'b1, 8'h12, 32'h0);
      xfer(1'b0, 1'b0, 1'b0, 8'h12, 32'h0);
      xfer(1'b1, 1'b1, 1'b0, 8'h20, 32'h12345678);
      xfer(1'b1, 1'b0, 1'b0, 8'h21, 32'hFFFFFFAA);
      xfer(1'b0, 1'b1, 1'b0, 8'h20, 32'h0);
      xfer(1'b1, 1'b1, 1'b0, 8'h31, 32'hCAFEF00D);
      xfer(1'b0, 1'b1, 1'b0, 8'h30, 32'h0);

      // Backpressure hold with an ignored request during RESP.
      rr_force = 1'b0;
      hold_exp = {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]};
      issue(1'b0, 1'b1, 1'b0, 8'h10, 32'h0, 1'b1, ok);
      budget = 0;
      while (!bus.rsp_valid && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      chk("hold_rsp_seen", {31'd0, bus.rsp_valid}, 32'd1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 1'b1;
      bus.req_addr = 8'h50; bus.req_wdata = ~{mem[8'h50], mem[8'h51], mem[8'h52], mem[8'h53]};
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
         chk("hold_rsp_rdata", bus.rsp_rdata, hold_exp);
         chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
      end
      rr_force = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("release_req_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("release_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      drain();
      xfer(1'b0, 1'b1, 1'b0, 8'h50, 32'h0);

      // Reset while a store sits in WAIT.
      old40 = mem[8'h40];
      issue(1'b1, 1'b0, 1'b0, 8'h40, {24'h0, ~old40}, 1'b0, ok);
      #2 rst_n = 1'b0;
      #1;
      chk("wait_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("wait_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      xfer(1'b0, 1'b0, 1'b0, 8'h40, 32'h0);
      chk("wait_rst_model", {24'h0, mem[8'h40]}, {24'h0, old40});

      bp_rand = 1'b1;
      for (int n = 0; n < 150; n++) begin
         xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)), $urandom);
      end
      bp_rand = 1'b0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
